// File: rtl/mem_stream_reader.sv
// Streams a contiguous, wrapping range of a block memory's read port out as a
// valid/ready stream, with a 2-entry skid FIFO covering the 1-cycle read latency.
module mem_stream_reader #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             mem_enB,
  output logic [AW-1:0]    mem_addrB,
  input  logic [WIDTH-1:0] mem_doutB,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [1:0]       dbg_state_o
);

  // Stream handshake: a word transfers on every rising edge where
  // m_valid && m_ready; while m_valid is high and m_ready low, m_data and
  // m_last hold. m_valid never depends on m_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    rd_addr_q;
  logic [AW:0]      issue_left_q;
  logic [AW:0]      pop_left_q;
  logic             inflight_q;
  logic [1:0]       occ_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [WIDTH-1:0] fifo_q [2];

  logic             pop_now;
  logic             issue;
  logic [2:0]       in_use;
  logic [1:0]       occ_d;
  logic [AW-1:0]    rd_addr_d;

  assign m_valid     = (occ_q != 2'd0);
  assign m_data      = fifo_q[rd_ptr_q];
  assign m_last      = m_valid && (pop_left_q == CNT_ONE);
  assign pop_now     = m_valid && m_ready;
  assign mem_enB     = issue;
  assign mem_addrB   = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Credit rule: a read may be issued only if its word is guaranteed a slot
  // when it lands next cycle, counting what leaves the FIFO this cycle.
  always_comb begin
    in_use    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_now};
    issue     = (state_q == READ) && (issue_left_q != '0) && (in_use < 3'd2);
    rd_addr_d = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_ONE;
    occ_d     = occ_q;
    case ({inflight_q, pop_now})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
    end else begin
      done_q     <= 1'b0;
      occ_q      <= occ_d;
      inflight_q <= issue;

      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_doutB;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_now) begin
        rd_ptr_q   <= ~rd_ptr_q;
        pop_left_q <= pop_left_q - CNT_ONE;
      end
      if (issue) begin
        rd_addr_q    <= rd_addr_d;
        issue_left_q <= issue_left_q - CNT_ONE;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              rd_addr_q    <= base_addr;
              issue_left_q <= count;
              pop_left_q   <= count;
              busy_q       <= 1'b1;
              state_q      <= READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue && (issue_left_q == CNT_ONE)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop_now && m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
